clock_divider_multi: RTL and testbench
======================================

// Module: clock_divider_multi
// PURPOSE
//  N-channel programmable clock divider and tick generator; successor to the fixed single-channel divider.
//  Each channel derives a divided clock (clk_out) and a 1-cycle tick from clk_in.
//  The divisor is runtime-writable through a valid/ready port and applied glitch-free at a period boundary.
//  A global sync pulse phase-aligns all channels. Feeds display scan, debounce and LED-blink logic.
// PARAMETERS
//  N_CH        4            number of channels (>=1)
//  DIV_WIDTH   32           width of divisor and counters
//  FREC_IN     100_000_000  clk_in frequency, Hz
//  FREC_OUT    30           default output frequency, Hz
//  DEFAULT_DIV FREC_IN/FREC_OUT  reset divisor of every channel, in clk_in cycles per output period
// PORTS
//  clk_in     in   1                 system clock, all logic on posedge
//  reset      in   1                 synchronous, active-high reset
//  en         in   N_CH              per-channel run enable
//  cfg_valid  in   1                 divisor write request
//  cfg_ready  out  1                 write accepted when cfg_valid&cfg_ready; = ~pending[cfg_ch] (combinational)
//  cfg_ch     in   max(1,clog2(N_CH)) target channel of write; values >= N_CH are ignored (accepted, no effect)
//  cfg_div    in   DIV_WIDTH         new divisor D (period in clk_in cycles)
//  sync       in   1                 restart all channels phase-aligned
//  clk_out    out  N_CH              divided clocks, registered
//  tick       out  N_CH              1-cycle pulse, high in the first cycle clk_out is high
//  pending    out  N_CH              channel holds an accepted, not yet applied divisor
// BEHAVIOUR
//  Clock and reset: one clock, clk_in; reset is synchronous and active-high.
//  Reset values: cnt=0, clk_out=0, tick=0, pending=0, div=DEFAULT_DIV, shadow discarded. cfg_ready then = 1.
//  Effective divisor: De = (div<2) ? 2 : div; high phase H = De - (De>>1); low phase De>>1.
//  Priority per channel, evaluated at each edge: reset > sync > ~en[i] > run.
//  Run, en[i]=1, at each edge:
//   - cnt==De-1 (wrap): cnt<=0, clk_out<=1, tick<=1.
//     If pending: div<=shadow, pending<=0; the new div applies from this period on.
//   - else if cnt==H-1: cnt<=cnt+1, clk_out<=0, tick<=0.
//   - else: cnt<=cnt+1, clk_out holds, tick<=0.
//   - De>=2 guarantees H-1 < De-1, so the wrap and fall conditions never collide.
//   - First tick comes De enabled edges after start; then tick every De cycles, clk_out high H, low De>>1.
//  en[i]=0: channel held at cnt=0, clk_out=0, tick=0. Any pending divisor is applied on that edge and pending cleared.
//   On en rising, the channel restarts exactly as after reset.
//  sync=1 (1-cycle pulse): all channels cnt<=0, clk_out<=0, tick<=0. Pending divisors are applied and cleared.
//  Config: accept = cfg_valid & cfg_ready.
//   On accept to channel c: shadow[c]<=cfg_div, pending[c]<=1, visible the next cycle.
//   Accept in the same cycle as a wrap, sync or en-low of channel c: pending is set and the divisor applies at
//   the NEXT boundary. The accept is never lost or applied early.
//  Counter arithmetic is unsigned, DIV_WIDTH bits. div = 2^DIV_WIDTH-1 is legal (no overflow, cnt max = De-1).
//  No combinational path from any input to clk_out or tick. cfg_ready depends combinationally on cfg_ch only.
// TESTING
//  T1 DEFAULT_DIV=4, en=1 after reset -> clk_out[0] rises after 4th edge; then 1100 repeating; tick every 4 cycles.
//  T2 cfg_div=5 to ch0 while en=0, then en=1 -> clk_out 11100 repeating, tick period 5, pending 1 for exactly 1 cycle.
//  T3 ch1 running D=4, write D=6 mid-period -> current period ends at 4, then period 6.
//     pending[1] high until the wrap; cfg_ready=0 for cfg_ch=1, while cfg_ch=2 is accepted the same cycle.
//  T4 cfg_div=0 and cfg_div=1 -> both behave as D=2: clk_out toggles every cycle, tick every 2 cycles.
//  T5 ch0 D=3, ch1 D=6 at random phases, sync pulse -> both clk_out 0 next cycle.
//     Then ticks coincide every 6 cycles; ch0 also ticks at 3.
//  T6 reset asserted mid-period with pending[2]=1 -> next cycle all outputs 0, pending 0, div=DEFAULT_DIV on every channel.

Source files
------------

// File: rtl/clock_divider_multi.sv
// N-channel programmable clock divider and tick generator.
// Each channel divides clk_in by a runtime-writable divisor.
//
// Ports:
//   clk_in    : system clock, all logic on posedge
//   reset     : synchronous, active-high
//   en        : per-channel run enable
//   cfg_valid : divisor write request
//   cfg_ready : write accepted when high (target channel not pending)
//   cfg_ch    : target channel (values >= N_CH accepted, ignored)
//   cfg_div   : new divisor, period in clk_in cycles
//   sync      : restart all channels phase-aligned
//   clk_out   : divided clocks, registered
//   tick      : one-cycle pulse on the first high cycle of clk_out
//   pending   : channel holds an accepted, not yet applied divisor
module clock_divider_multi #(
    parameter int N_CH        = 4,
    parameter int DIV_WIDTH   = 32,
    parameter int FREC_IN     = 100_000_000,
    parameter int FREC_OUT    = 30,
    parameter int DEFAULT_DIV = FREC_IN / FREC_OUT,
    localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic [N_CH-1:0]      en,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [CH_W-1:0]      cfg_ch,
    input  logic [DIV_WIDTH-1:0] cfg_div,
    input  logic                 sync,
    output logic [N_CH-1:0]      clk_out,
    output logic [N_CH-1:0]      tick,
    output logic [N_CH-1:0]      pending
);

    logic accept;

    // Out-of-range channels never block, so their writes drain harmlessly.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = ~pending[i];
            end
        end
    end

    assign accept = cfg_valid & cfg_ready;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [DIV_WIDTH-1:0] div;
        logic [DIV_WIDTH-1:0] shadow;
        logic [DIV_WIDTH-1:0] cnt;
        logic [DIV_WIDTH-1:0] de;
        logic [DIV_WIDTH-1:0] h_last;
        logic [DIV_WIDTH-1:0] p_last;
        logic                 pend_r;
        logic                 clk_r;
        logic                 tick_r;
        logic                 sel;
        logic                 wrap;
        logic                 boundary;

        // Divisors below 2 cannot form a high and a low phase.
        always_comb begin
            de     = (div < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : div;
            h_last = de - (de >> 1) - DIV_WIDTH'(1);
            p_last = de - DIV_WIDTH'(1);
        end

        assign sel      = accept & (cfg_ch == CH_W'(i));
        assign wrap     = (cnt == p_last);
        assign boundary = sync | ~en[i] | wrap;

        always_ff @(posedge clk_in) begin
            if (reset) begin
                div    <= DIV_WIDTH'(DEFAULT_DIV);
                shadow <= '0;
                cnt    <= '0;
                pend_r <= 1'b0;
                clk_r  <= 1'b0;
                tick_r <= 1'b0;
            end else begin
                // A write is only accepted while not pending, so an
                // accept never coincides with applying the old shadow.
                if (pend_r && boundary) begin
                    div    <= shadow;
                    pend_r <= 1'b0;
                end
                if (sel) begin
                    shadow <= cfg_div;
                    pend_r <= 1'b1;
                end

                if (sync || !en[i]) begin
                    cnt    <= '0;
                    clk_r  <= 1'b0;
                    tick_r <= 1'b0;
                end else if (wrap) begin
                    cnt    <= '0;
                    clk_r  <= 1'b1;
                    tick_r <= 1'b1;
                end else if (cnt == h_last) begin
                    cnt    <= cnt + DIV_WIDTH'(1);
                    clk_r  <= 1'b0;
                    tick_r <= 1'b0;
                end else begin
                    cnt    <= cnt + DIV_WIDTH'(1);
                    tick_r <= 1'b0;
                end
            end
        end

        assign pending[i] = pend_r;
        assign clk_out[i] = clk_r;
        assign tick[i]    = tick_r;
    end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Testbench for clock_divider_multi.
// Directed stimulus; expectations queued and checked by a monitor.
module tb_clock_divider_multi;

    localparam int N_CH = 4;
    localparam int DW   = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    en;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [1:0]    cfg_ch;
    logic [DW-1:0] cfg_div;
    logic          sync;
    logic [3:0]    clk_out;
    logic [3:0]    tick;
    logic [3:0]    pending;

    clock_divider_multi #(
        .N_CH       (N_CH),
        .DIV_WIDTH  (DW),
        .DEFAULT_DIV(4)
    ) dut (
        .clk_in   (clk),
        .reset    (reset),
        .en       (en),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .sync     (sync),
        .clk_out  (clk_out),
        .tick     (tick),
        .pending  (pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         at;
        string      tag;
        bit         is_rdy;
        logic [3:0] mask;
        logic [3:0] c;
        logic [3:0] t;
        logic [3:0] p;
        logic       r;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    int t1c[12] = '{0,0,0,1,1,0,0,1,1,0,0,1};
    int t1t[12] = '{0,0,0,1,0,0,0,1,0,0,0,1};
    int t2c[15] = '{0,0,0,0,1,1,1,0,0,1,1,1,0,0,1};
    int t2t[15] = '{0,0,0,0,1,0,0,0,0,1,0,0,0,0,1};
    int t3c[12] = '{1,1,0,0,0,1,1,1,0,0,0,1};
    int t3t[12] = '{0,0,0,0,0,1,0,0,0,0,0,1};
    int t4c[6]  = '{0,1,0,1,0,1};
    int t5c0[12] = '{0,0,1,1,0,1,1,0,1,1,0,1};
    int t5t0[12] = '{0,0,1,0,0,1,0,0,1,0,0,1};
    int t5c1[12] = '{0,0,0,0,0,1,1,1,0,0,0,1};
    int t5t1[12] = '{0,0,0,0,0,1,0,0,0,0,0,1};

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation due at this cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].at <= cyc) begin
            exp_t x;
            bit   ok;
            x = q.pop_front();
            checks++;
            if (x.is_rdy) begin
                ok = (cfg_ready === x.r);
            end else begin
                ok = ((clk_out & x.mask) === (x.c & x.mask)) &&
                     ((tick & x.mask) === (x.t & x.mask)) &&
                     ((pending & x.mask) === (x.p & x.mask));
            end
            if (!ok) begin
                errors++;
                if (x.is_rdy)
                    $display("FAIL %s cyc %0d: cfg_ready=%b required %b",
                             x.tag, cyc, cfg_ready, x.r);
                else
                    $display("FAIL %s cyc %0d mask %b: clk_out=%b tick=%b pending=%b required clk_out=%b tick=%b pending=%b",
                             x.tag, cyc, x.mask, clk_out, tick, pending,
                             x.c & x.mask, x.t & x.mask, x.p & x.mask);
            end
        end
    end

    function automatic void evec(int k, string tag, logic [3:0] m,
                                 logic [3:0] c, logic [3:0] t,
                                 logic [3:0] p);
        exp_t x;
        x.at = cyc + k; x.tag = tag; x.is_rdy = 1'b0;
        x.mask = m; x.c = c; x.t = t; x.p = p; x.r = 1'b0;
        q.push_back(x);
    endfunction

    function automatic void ech(int k, string tag, int ch,
                                int c, int t, int p);
        logic [3:0] m;
        m = 4'b0001 << ch;
        evec(k, tag, m, (c != 0) ? m : 4'b0, (t != 0) ? m : 4'b0,
             (p != 0) ? m : 4'b0);
    endfunction

    function automatic void erdy(int k, string tag, logic r);
        exp_t x;
        x.at = cyc + k; x.tag = tag; x.is_rdy = 1'b1;
        x.mask = '0; x.c = '0; x.t = '0; x.p = '0; x.r = r;
        q.push_back(x);
    endfunction

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        reset = 1'b1; en = '0; cfg_valid = 1'b0;
        cfg_ch = '0; cfg_div = '0; sync = 1'b0;
        step(3);
        evec(0, "reset", 4'hF, 4'h0, 4'h0, 4'h0);
        erdy(0, "reset_rdy", 1'b1);

        // Default divisor 4 on channel 0
        reset = 1'b0;
        en = 4'b0001;
        for (int j = 1; j <= 12; j++)
            ech(j, "t1_def4", 0, t1c[j-1], t1t[j-1], 0);
        step(12);

        // Divisor 5 written while disabled
        en = 4'b0000;
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd5;
        erdy(0, "t2_rdy", 1'b1);
        step(1);
        cfg_valid = 1'b0;
        ech(0, "t2_pend_set", 0, 0, 0, 1);
        step(1);
        ech(0, "t2_pend_clr", 0, 0, 0, 0);
        en = 4'b0001;
        for (int j = 1; j <= 15; j++)
            ech(j, "t2_div5", 0, t2c[j-1], t2t[j-1], 0);
        step(15);

        // Mid-period rewrite of channel 1
        en = 4'b0010;
        step(9);
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd6;
        erdy(0, "t3_rdy_ch1", 1'b1);
        ech(0, "t3_pre", 1, 1, 0, 0);
        step(1);
        cfg_ch = 2'd1; cfg_div = 8'd9;
        erdy(0, "t3_busy_ch1", 1'b0);
        ech(0, "t3_pend", 1, 0, 0, 1);
        step(1);
        cfg_ch = 2'd2; cfg_div = 8'd3;
        erdy(0, "t3_rdy_ch2", 1'b1);
        ech(0, "t3_hold", 1, 0, 0, 1);
        step(1);
        cfg_valid = 1'b0;
        ech(0, "t3_wrap", 1, 1, 1, 0);
        ech(0, "t3_p2_set", 2, 0, 0, 1);
        ech(1, "t3_p2_clr", 2, 0, 0, 0);
        for (int j = 1; j <= 12; j++)
            ech(j, "t3_div6", 1, t3c[j-1], t3t[j-1], 0);
        step(12);

        // Divisors 0 and 1 behave as 2
        en = 4'b0000;
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd0;
        step(1);
        cfg_ch = 2'd3; cfg_div = 8'd1;
        ech(0, "t4_p0", 0, 0, 0, 1);
        step(1);
        cfg_valid = 1'b0;
        ech(0, "t4_p3", 3, 0, 0, 1);
        step(1);
        en = 4'b1001;
        for (int j = 1; j <= 6; j++) begin
            ech(j, "t4_div0", 0, t4c[j-1], t4c[j-1], 0);
            ech(j, "t4_div1", 3, t4c[j-1], t4c[j-1], 0);
        end
        step(6);

        // Sync aligns divisors 3 and 6
        en = 4'b0011;
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd3;
        step(1);
        cfg_valid = 1'b0;
        step(4);
        sync = 1'b1;
        step(1);
        sync = 1'b0;
        evec(0, "t5_sync", 4'b0011, 4'h0, 4'h0, 4'h0);
        for (int j = 1; j <= 12; j++)
            evec(j, "t5_align", 4'b0011,
                 4'(t5c1[j-1] * 2 + t5c0[j-1]),
                 4'(t5t1[j-1] * 2 + t5t0[j-1]), 4'h0);
        step(12);

        // Reset with a pending write on channel 2
        en = 4'b0111;
        step(2);
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd7;
        step(1);
        cfg_valid = 1'b0;
        ech(0, "t6_pend_wrap", 2, 1, 1, 1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        en = 4'b1111;
        evec(0, "t6_reset", 4'hF, 4'h0, 4'h0, 4'h0);
        erdy(0, "t6_rdy", 1'b1);
        for (int j = 1; j <= 8; j++)
            evec(j, "t6_default", 4'hF,
                 (t1c[j-1] != 0) ? 4'hF : 4'h0,
                 (t1t[j-1] != 0) ? 4'hF : 4'h0, 4'h0);
        step(8);

        // Largest divisor
        en = 4'b0000;
        cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd255;
        step(1);
        cfg_valid = 1'b0;
        step(1);
        en = 4'b1000;
        ech(254, "t7_pre", 3, 0, 0, 0);
        ech(255, "t7_tick", 3, 1, 1, 0);
        ech(256, "t7_high", 3, 1, 0, 0);
        ech(382, "t7_hlast", 3, 1, 0, 0);
        ech(383, "t7_fall", 3, 0, 0, 0);
        ech(510, "t7_tick2", 3, 1, 1, 0);
        step(512);

        if (q.size() != 0) begin
            $display("FAIL scoreboard_drain: %0d left, required 0",
                     q.size());
            errors += q.size();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
